// File: rtl/instr_fetch_if.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_if
// Description : Bundles the fetch unit's memory, redirect and decode ports.
// Revision    : 1.0 - initial release
// ============================================================================
interface instr_fetch_if #(
  parameter int wd_instr_p = 32,
  parameter int wd_pc_p    = 32
);
  logic                  o_imem_req_valid;
  logic                  i_imem_req_ready;
  logic [wd_pc_p-1:0]    o_imem_addr;
  logic                  i_imem_rsp_valid;
  logic [wd_instr_p-1:0] i_imem_rsp_data;
  logic                  i_redirect_valid;
  logic [wd_pc_p-1:0]    i_redirect_pc;
  logic                  o_instr_valid;
  logic                  i_instr_ready;
  logic [wd_instr_p-1:0] o_instr;
  logic [wd_pc_p-1:0]    o_instr_pc;

  modport master (
    output o_imem_req_valid, o_imem_addr, o_instr_valid, o_instr, o_instr_pc,
    input  i_imem_req_ready, i_imem_rsp_valid, i_imem_rsp_data,
           i_redirect_valid, i_redirect_pc, i_instr_ready
  );

  modport slave (
    input  o_imem_req_valid, o_imem_addr, o_instr_valid, o_instr, o_instr_pc,
    output i_imem_req_ready, i_imem_rsp_valid, i_imem_rsp_data,
           i_redirect_valid, i_redirect_pc, i_instr_ready
  );
endinterface
`default_nettype wire

// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch
// Description : Credit-limited instruction fetch with in-order response buffer
//               and redirect flush. ARRISKV_IFETCH_BYPASS_EN enables a
//               combinational response-to-decode bypass.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch #(
  parameter int                 wd_instr_p = 32,
  parameter int                 wd_pc_p    = 32,
  parameter logic [wd_pc_p-1:0] reset_pc_p = 32'h0000_0000,
  parameter int                 depth_p    = 2
) (
  input  logic          clk,
  input  logic          rst,
  instr_fetch_if.master bus
);
  localparam int                 c_ptr_w      = $clog2(depth_p);
  localparam int                 c_cnt_w      = $clog2(depth_p + 1);
  localparam logic [wd_pc_p-1:0] c_pc_step    = wd_pc_p'(4);
  localparam logic [wd_pc_p-1:0] c_align_mask = ~(wd_pc_p'(3));
  localparam logic [wd_pc_p-1:0] c_reset_pc   = reset_pc_p & c_align_mask;

  logic [wd_pc_p-1:0]    r_fetch_pc;
  logic [wd_pc_p-1:0]    r_rsp_pc;
  logic [c_cnt_w-1:0]    r_outstanding;
  logic [c_cnt_w-1:0]    r_drop;
  logic [c_cnt_w-1:0]    r_count;
  logic [c_ptr_w-1:0]    r_wr_ptr;
  logic [c_ptr_w-1:0]    r_rd_ptr;
  logic [wd_instr_p-1:0] r_buf_data [depth_p];
  logic [wd_pc_p-1:0]    r_buf_pc   [depth_p];

  logic                  w_buf_empty;
  logic                  w_rsp_hit;
  logic                  w_rsp_keep;
  logic                  w_bypass;
  logic                  w_push;
  logic                  w_buf_pop;
  logic [c_cnt_w:0]      w_credit;
  logic                  w_req_valid;
  logic                  w_accept;
  logic [c_cnt_w-1:0]    w_out_next;
  logic [wd_pc_p-1:0]    w_redirect_tgt;

  assign w_buf_empty    = (r_count == '0);
  // Responses with nothing outstanding belong to requests abandoned by reset.
  assign w_rsp_hit      = bus.i_imem_rsp_valid && (r_outstanding != '0);
  assign w_rsp_keep     = w_rsp_hit && (r_drop == '0) && !bus.i_redirect_valid;
  assign w_buf_pop      = !rst && !w_buf_empty && bus.i_instr_ready;
  assign w_redirect_tgt = bus.i_redirect_pc & c_align_mask;

`ifdef ARRISKV_IFETCH_BYPASS_EN
  assign w_bypass = w_rsp_keep && w_buf_empty;
  assign w_push   = w_rsp_keep && !(w_bypass && bus.i_instr_ready);
`else
  assign w_bypass = 1'b0;
  assign w_push   = w_rsp_keep;
`endif

  // A slot vacated by this cycle's pop may be reissued immediately, which is
  // what sustains one fetch per cycle with a two-entry buffer.
  assign w_credit    = {1'b0, r_outstanding} + {1'b0, r_count}
                     - (c_cnt_w + 1)'(w_buf_pop);
  assign w_req_valid = !rst && !bus.i_redirect_valid
                     && (w_credit < (c_cnt_w + 1)'(depth_p));
  assign w_accept    = w_req_valid && bus.i_imem_req_ready;
  assign w_out_next  = r_outstanding + c_cnt_w'(w_accept) - c_cnt_w'(w_rsp_hit);

  assign bus.o_imem_req_valid = w_req_valid;
  assign bus.o_imem_addr      = r_fetch_pc;

  always_comb begin
    bus.o_instr_valid = 1'b0;
    bus.o_instr       = '0;
    bus.o_instr_pc    = '0;
    if (!rst) begin
      if (!w_buf_empty) begin
        bus.o_instr_valid = 1'b1;
        bus.o_instr       = r_buf_data[r_rd_ptr];
        bus.o_instr_pc    = r_buf_pc[r_rd_ptr];
      end else if (w_bypass) begin
        bus.o_instr_valid = 1'b1;
        bus.o_instr       = bus.i_imem_rsp_data;
        bus.o_instr_pc    = r_rsp_pc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_pc    <= c_reset_pc;
      r_rsp_pc      <= c_reset_pc;
      r_outstanding <= '0;
      r_drop        <= '0;
      r_count       <= '0;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
    end else begin
      r_outstanding <= w_out_next;
      if (bus.i_redirect_valid) begin
        // Everything still in flight after this cycle is stale.
        r_fetch_pc <= w_redirect_tgt;
        r_rsp_pc   <= w_redirect_tgt;
        r_drop     <= w_out_next;
        r_count    <= '0;
        r_wr_ptr   <= '0;
        r_rd_ptr   <= '0;
      end else begin
        if (w_accept) begin
          r_fetch_pc <= r_fetch_pc + c_pc_step;
        end
        if (w_rsp_hit && (r_drop != '0)) begin
          r_drop <= r_drop - 1'b1;
        end
        if (w_rsp_keep) begin
          r_rsp_pc <= r_rsp_pc + c_pc_step;
        end
        if (w_push) begin
          r_wr_ptr <= r_wr_ptr + 1'b1;
        end
        if (w_buf_pop) begin
          r_rd_ptr <= r_rd_ptr + 1'b1;
        end
        r_count <= r_count + c_cnt_w'(w_push) - c_cnt_w'(w_buf_pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && w_push) begin
      r_buf_data[r_wr_ptr] <= bus.i_imem_rsp_data;
      r_buf_pc[r_wr_ptr]   <= r_rsp_pc;
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_fetch
// Description : Directed self-checking bench for instr_fetch.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch;
`ifdef ARRISKV_IFETCH_BYPASS_EN
  localparam int c_lat = 1;
`else
  localparam int c_lat = 2;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  instr_fetch_if #(.wd_instr_p(32), .wd_pc_p(32)) bus ();
  instr_fetch_if #(.wd_instr_p(32), .wd_pc_p(32)) bus2 ();

  instr_fetch #(.wd_instr_p(32), .wd_pc_p(32), .reset_pc_p(32'h0000_0000), .depth_p(2))
    dut (.clk(clk), .rst(rst), .bus(bus));
  instr_fetch #(.wd_instr_p(32), .wd_pc_p(32), .reset_pc_p(32'hFFFF_FFF8), .depth_p(2))
    dut2 (.clk(clk), .rst(rst), .bus(bus2));

  int          checks = 0;
  int          errors = 0;
  logic [31:0] q[$];
  logic [31:0] addr2[$];
  bit          rsp_en = 1'b1;
  logic [31:0] exp_addr = 32'h0;
  logic [31:0] exp_pc   = 32'h0;
  int          accs, pops, cyc, first_pop_cyc, pops_mark;
  bit          acc2, pop2_seen;
  logic [31:0] acc2_addr, pop2_first, held_pc;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  task automatic cycle();
    @(negedge clk);
    if (bus.i_imem_rsp_valid && q.size() > 0) void'(q.pop_front());
    if (bus.o_imem_req_valid && bus.i_imem_req_ready) begin
      check_eq("imem_addr", bus.o_imem_addr, exp_addr);
      q.push_back(bus.o_imem_addr);
      exp_addr += 32'd4;
      accs++;
    end
    if (bus.o_instr_valid && bus.i_instr_ready) begin
      check_eq("instr_pc", bus.o_instr_pc, exp_pc);
      check_eq("instr_data", bus.o_instr, mem_word(exp_pc));
      exp_pc += 32'd4;
      pops++;
      if (first_pop_cyc < 0) first_pop_cyc = cyc;
    end
    if (bus.i_redirect_valid) begin
      check_eq("req_during_redirect", {31'b0, bus.o_imem_req_valid}, 32'd0);
      exp_addr = bus.i_redirect_pc & ~32'h3;
      exp_pc   = bus.i_redirect_pc & ~32'h3;
    end
    if (rst) begin
      exp_addr = 32'h0;
      exp_pc   = 32'h0;
    end
    acc2      = bus2.o_imem_req_valid;
    acc2_addr = bus2.o_imem_addr;
    if (!rst && acc2 && addr2.size() < 3) addr2.push_back(bus2.o_imem_addr);
    if (!rst && bus2.o_instr_valid && !pop2_seen) begin
      pop2_seen  = 1'b1;
      pop2_first = bus2.o_instr_pc;
    end
    @(posedge clk);
    #1;
    cyc++;
    bus.i_imem_rsp_valid  = rsp_en && (q.size() > 0) && !rst;
    bus.i_imem_rsp_data   = (q.size() > 0) ? mem_word(q[0]) : 32'h0;
    bus2.i_imem_rsp_valid = acc2 && !rst;
    bus2.i_imem_rsp_data  = mem_word(acc2_addr);
  endtask

  initial begin
    bus.i_imem_req_ready  = 1'b1;
    bus.i_imem_rsp_valid  = 1'b0;
    bus.i_imem_rsp_data   = 32'h0;
    bus.i_redirect_valid  = 1'b0;
    bus.i_redirect_pc     = 32'h0;
    bus.i_instr_ready     = 1'b1;
    bus2.i_imem_req_ready = 1'b1;
    bus2.i_imem_rsp_valid = 1'b0;
    bus2.i_imem_rsp_data  = 32'h0;
    bus2.i_redirect_valid = 1'b0;
    bus2.i_redirect_pc    = 32'h0;
    bus2.i_instr_ready    = 1'b1;
    first_pop_cyc = -1;

    // Reset state
    rst = 1'b1;
    repeat (3) cycle();
    #1;
    check_eq("rst_req_valid", {31'b0, bus.o_imem_req_valid}, 32'd0);
    check_eq("rst_instr_valid", {31'b0, bus.o_instr_valid}, 32'd0);
    check_eq("rst_instr", bus.o_instr, 32'h0);
    check_eq("rst_instr_pc", bus.o_instr_pc, 32'h0);

    // Release and stream
    @(posedge clk); #1;
    rst = 1'b0; cyc = 0; accs = 0; pops = 0; first_pop_cyc = -1;
    #1;
    check_eq("first_req_valid", {31'b0, bus.o_imem_req_valid}, 32'd1);
    check_eq("first_req_addr", bus.o_imem_addr, 32'h0);
    repeat (10) cycle();
    check_eq("stream_accepts", accs, 32'd10);
    check_eq("stream_pops", pops, 32'(10 - c_lat));
    check_eq("first_pop_cycle", first_pop_cyc, 32'(c_lat));

    // Decode stall
    bus.i_instr_ready = 1'b0;
    #1;
    held_pc = bus.o_instr_pc;
    repeat (5) cycle();
    #1;
    check_eq("stall_req_valid", {31'b0, bus.o_imem_req_valid}, 32'd0);
    check_eq("stall_instr_valid", {31'b0, bus.o_instr_valid}, 32'd1);
    check_eq("stall_pc_held", bus.o_instr_pc, held_pc);
    check_eq("stall_instr_held", bus.o_instr, mem_word(held_pc));
    bus.i_instr_ready = 1'b1;
    repeat (8) cycle();

    // Redirect with two requests in flight
    rsp_en = 1'b0;
    bus.i_imem_rsp_valid = 1'b0;
    repeat (4) cycle();
    #1;
    check_eq("inflight_req_valid", {31'b0, bus.o_imem_req_valid}, 32'd0);
    check_eq("inflight_instr_valid", {31'b0, bus.o_instr_valid}, 32'd0);
    bus.i_redirect_valid = 1'b1;
    bus.i_redirect_pc    = 32'h0000_0103;
    cycle();
    bus.i_redirect_valid = 1'b0;
    rsp_en = 1'b1;
    #1;
    check_eq("redirect_addr", bus.o_imem_addr, 32'h0000_0100);
    pops_mark = pops;
    repeat (8) cycle();
    check_eq("redirect_pops", pops - pops_mark, 32'(6 - c_lat));

    // Redirect coinciding with response and pop
    bus.i_redirect_valid = 1'b1;
    bus.i_redirect_pc    = 32'h0000_0200;
    #1;
    check_eq("flush_pre_valid", {31'b0, bus.o_instr_valid}, (c_lat == 2) ? 32'd1 : 32'd0);
    cycle();
    bus.i_redirect_valid = 1'b0;
    #1;
    check_eq("flush_instr_valid", {31'b0, bus.o_instr_valid}, 32'd0);
    check_eq("flush_req_valid", {31'b0, bus.o_imem_req_valid}, 32'd1);
    check_eq("flush_addr", bus.o_imem_addr, 32'h0000_0200);
    pops_mark = pops;
    repeat (6) cycle();
    check_eq("flush_pops", pops - pops_mark, 32'(6 - c_lat));

    // Memory backpressure toggling, then reset mid-stream
    repeat (10) begin
      bus.i_imem_req_ready = ~bus.i_imem_req_ready;
      cycle();
    end
    rst = 1'b1;
    q.delete();
    cycle();
    cycle();
    #1;
    check_eq("midrst_req_valid", {31'b0, bus.o_imem_req_valid}, 32'd0);
    check_eq("midrst_instr_valid", {31'b0, bus.o_instr_valid}, 32'd0);
    rst = 1'b0;
    bus.i_imem_req_ready = 1'b1;
    bus.i_imem_rsp_valid = 1'b1;
    bus.i_imem_rsp_data  = 32'hDEAD_BEEF;
    #1;
    check_eq("postrst_req_valid", {31'b0, bus.o_imem_req_valid}, 32'd1);
    check_eq("postrst_addr", bus.o_imem_addr, 32'h0);
    pops_mark = pops;
    repeat (8) cycle();
    check_eq("postrst_pops", pops - pops_mark, 32'(8 - c_lat));

    // PC wrap on the second instance
    check_eq("wrap_naddr", addr2.size(), 32'd3);
    if (addr2.size() >= 3) begin
      check_eq("wrap_addr0", addr2[0], 32'hFFFF_FFF8);
      check_eq("wrap_addr1", addr2[1], 32'hFFFF_FFFC);
      check_eq("wrap_addr2", addr2[2], 32'h0000_0000);
    end
    check_eq("wrap_first_pc", pop2_first, 32'hFFFF_FFF8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter wd_instr_p, default 32, instruction width.
REQ-002 SHALL have parameter wd_pc_p, default 32, PC/address width.
REQ-003 SHALL have parameter reset_pc_p, default 32'h0000_0000, PC loaded at reset.
REQ-004 SHALL have parameter depth_p, default 2, instruction buffer entries (power of 2, >=2).
REQ-005 SHALL have one clock and a synchronous, active-high reset; ports: clk input 1, rising-edge clock; rst input 1, synchronous active-high reset.
REQ-006 SHALL have o_imem_req_valid output 1, fetch request valid.
REQ-007 SHALL have i_imem_req_ready input 1, memory accepts request.
REQ-008 SHALL have o_imem_addr output wd_pc_p, fetch address, word aligned.
REQ-009 SHALL have i_imem_rsp_valid input 1, read data valid; responses in request order, >=1 cycle after acceptance.
REQ-010 SHALL have i_imem_rsp_data input wd_instr_p, fetched word.
REQ-011 SHALL have i_redirect_valid input 1, branch/jump redirect from execute.
REQ-012 SHALL have i_redirect_pc input wd_pc_p, redirect target.
REQ-013 SHALL have o_instr_valid output 1, instruction available to decode.
REQ-014 SHALL have i_instr_ready input 1, decode consumes instruction.
REQ-015 SHALL have o_instr output wd_instr_p, instruction word (feeds decode i_instr).
REQ-016 SHALL have o_instr_pc output wd_pc_p, PC of o_instr.

Function
REQ-017 Request accepted when o_imem_req_valid && i_imem_req_ready; fetch PC then advances by 4, mod 2^wd_pc_p (wrap from 0xFFFF_FFFC to 0).
REQ-018 o_imem_req_valid SHALL be 1 only when outstanding + buffer occupancy < depth_p and i_redirect_valid is 0; o_imem_addr = fetch PC.
REQ-019 Outstanding counter: +1 on acceptance, -1 on response, both same cycle -> unchanged; never exceeds depth_p.
REQ-020 Response with drop counter = 0 SHALL push {data, PC} into FIFO buffer; PC tracked by a separate response-PC register advancing by 4 per kept response.
REQ-021 Response with drop counter > 0 SHALL be discarded and decrement drop counter.
REQ-022 o_instr_valid = buffer non-empty; pop on o_instr_valid && i_instr_ready; o_instr/o_instr_pc stable while valid && !ready.
REQ-023 Simultaneous push and pop on full buffer SHALL be legal; push on full without pop cannot occur (guaranteed by REQ-018).
REQ-024 Redirect (single cycle): buffer flushed, fetch PC and response PC <= {i_redirect_pc[wd_pc_p-1:2], 2'b00}, no request issued, any response arriving that cycle discarded, drop counter <= in-flight count after that cycle's response.
REQ-025 Redirect in a cycle where a pop also occurs SHALL flush; o_instr_valid = 0 next cycle.
REQ-026 Back-to-back redirects: latest target wins, drop counter recomputed each cycle.
REQ-027 Sustained throughput: 1 instruction/cycle with 1-cycle memory and depth_p >= 2.

Reset
REQ-028 While rst = 1: fetch PC and response PC = reset_pc_p, outstanding = 0, drop = 0, buffer empty, o_imem_req_valid = 0, o_instr_valid = 0, o_instr = 0, o_instr_pc = 0.
REQ-029 Reset mid-operation SHALL abandon in-flight requests; responses arriving the cycle after reset deassertion with outstanding = 0 SHALL be ignored.
REQ-030 First request SHALL be issued the first cycle after rst deasserts, address reset_pc_p.

Configuration
REQ-031 Macro ARRISKV_IFETCH_BYPASS_EN defined: response arriving with buffer empty (or emptying by pop), drop = 0, no redirect, SHALL drive o_instr_valid/o_instr/o_instr_pc combinationally the same cycle; consumed if i_instr_ready, else buffered.
REQ-032 Macro not defined: all downstream outputs registered; minimum response-to-o_instr_valid latency 1 cycle.

Verification
REQ-033 Reset release, 1-cycle memory, ready = 1 -> addresses 0x0,0x4,0x8...; o_instr_pc sequence 0x0,0x4,0x8, one per cycle after fill.
REQ-034 i_instr_ready = 0 for 5 cycles -> o_imem_req_valid drops once outstanding + occupancy = 2; o_instr/o_instr_pc held; no loss on resume.
REQ-035 Redirect to 0x103 with 2 in flight -> next address 0x100, both stale responses dropped, first o_instr_pc = 0x100.
REQ-036 Redirect same cycle as response and pop -> response discarded, o_instr_valid = 0 next cycle, fetch resumes at target.
REQ-037 reset_pc_p = 0xFFFF_FFF8 -> addresses 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0.
REQ-038 i_imem_req_ready toggling 1/0, rst asserted mid-stream -> no duplicate or skipped PCs; after rst, first address reset_pc_p; with ARRISKV_IFETCH_BYPASS_EN, rsp at cycle N gives o_instr_valid at cycle N.
